proc_ctrl_fsm: RTL and testbench

- Instruction-sequencing control unit for the 16-bit, 8-register base processor.
- Latches each instruction word from `din` on `run`.
- Steps a 4-state FSM (T0..T3) that drives:
  - register write enables,
  - the shared-bus mux select,
  - the A/G ALU register loads and add/sub select.
- Raises `done` on the final cycle of each instruction.
- Sits between the instruction source (`din`/`run`) and the register-file/ALU datapath that the mv/mvi bench exercises.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/proc_ctrl_fsm_if.sv | 15 +
 rtl/proc_ctrl_fsm_dec3to8.sv | 8 +
 rtl/proc_ctrl_fsm.sv | 81 ++++++++
 tb/tb_proc_ctrl_fsm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, FSM states, bus-select codes and instruction field positions
package proc_pkg;
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam logic [3:0] SEL_R0   = 4'd0;
    localparam logic [3:0] SEL_R1   = 4'd1;
    localparam logic [3:0] SEL_R2   = 4'd2;
    localparam logic [3:0] SEL_R3   = 4'd3;
    localparam logic [3:0] SEL_R4   = 4'd4;
    localparam logic [3:0] SEL_R5   = 4'd5;
    localparam logic [3:0] SEL_R6   = 4'd6;
    localparam logic [3:0] SEL_R7   = 4'd7;
    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;
    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int RX_HI = 12;
    localparam int RX_LO = 10;
    localparam int RY_HI = 9;
    localparam int RY_LO = 7;
endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// proc_ctrl_fsm_if: instruction source and datapath control signals of the sequencer
interface proc_ctrl_fsm_if #(parameter int DATA_W = 16, parameter int NREG = 8);
    logic              run;
    logic [DATA_W-1:0] din;
    logic [NREG-1:0]   r_in;
    logic              a_in;
    logic              g_in;
    logic              addsub;
    logic [3:0]        bus_sel;
    logic              done;
    logic              busy;
    logic              illegal;
    modport master (output run, din, input r_in, a_in, g_in, addsub, bus_sel, done, busy, illegal);
    modport slave (input run, din, output r_in, a_in, g_in, addsub, bus_sel, done, busy, illegal);
endinterface

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// dec3to8: 3-bit index to one-hot 8 with enable
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);
    assign y = en ? 8'(1) << sel : 8'h00;
endmodule

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: T0..T3 instruction sequencer driving register enables, bus select and ALU loads
module proc_ctrl_fsm import proc_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic          clock,
    input logic          reset,
    proc_ctrl_fsm_if.slave ctrl
);
    if (DATA_W != 16 || NREG != 8) begin : g_bad_params
        $error("proc_ctrl_fsm supports only DATA_W=16 and NREG=8");
    end
    state_t            state, state_n;
    logic [DATA_W-1:0] ir;
    logic [2:0]        op, rx, ry;
    logic              wr;
    logic              unused_ir;
    assign op = ir[OP_HI:OP_LO];
    assign rx = ir[RX_HI:RX_LO];
    assign ry = ir[RY_HI:RY_LO];
    assign unused_ir = ^ir[RY_LO-1:0];
    assign ctrl.busy = state != T0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == T0 && ctrl.run) ir <= ctrl.din;
        end
    end
    always_comb begin
        state_n      = state;
        wr           = 1'b0;
        ctrl.a_in    = 1'b0;
        ctrl.g_in    = 1'b0;
        ctrl.addsub  = 1'b0;
        ctrl.done    = 1'b0;
        ctrl.illegal = 1'b0;
        ctrl.bus_sel = SEL_NONE;
        case (state)
            T0: state_n = ctrl.run ? T1 : T0;
            T1: begin
                state_n = (op == OP_ADD || op == OP_SUB) ? T2 : T0;
                case (op)
                    OP_MV: begin
                        ctrl.bus_sel = {1'b0, ry};
                        wr           = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_MVI: begin
                        ctrl.bus_sel = SEL_DIN;
                        wr           = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.bus_sel = {1'b0, rx};
                        ctrl.a_in    = 1'b1;
                    end
                    default: begin
                        ctrl.done    = 1'b1;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                state_n      = T3;
                ctrl.bus_sel = {1'b0, ry};
                ctrl.g_in    = 1'b1;
                ctrl.addsub  = op == OP_SUB;
            end
            default: begin
                state_n      = T0;
                ctrl.bus_sel = SEL_G;
                wr           = 1'b1;
                ctrl.done    = 1'b1;
            end
        endcase
    end
    dec3to8 u_dec (.en(wr), .sel(rx), .y(ctrl.r_in));
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: scoreboard bench for the sequencer with a small register-file/ALU model on its outputs
module tb_proc_ctrl_fsm;
    typedef struct packed {logic rst; logic run; logic [15:0] din;} stim_t;
    localparam logic [17:0] IDLE = {8'h00, 3'b000, 4'hf, 3'b000};
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic seed = 1'b0;
    int tests = 0;
    int fails = 0;
    stim_t sq[$];
    logic [17:0] eq[$];
    logic [15:0] rf[8];
    logic [15:0] ra, rg, dbus;
    logic [17:0] obs;
    always #5 clock = ~clock;
    proc_ctrl_fsm_if #(.DATA_W(16), .NREG(8)) bus_if ();
    proc_ctrl_fsm #(.DATA_W(16), .NREG(8)) dut (.clock(clock), .reset(reset), .ctrl(bus_if.slave));
    assign obs = {bus_if.r_in, bus_if.a_in, bus_if.g_in, bus_if.addsub, bus_if.bus_sel,
                  bus_if.done, bus_if.busy, bus_if.illegal};
    // Datapath model so register contents can be checked after each instruction
    always_comb dbus = bus_if.bus_sel < 4'd8 ? rf[bus_if.bus_sel[2:0]] :
                       bus_if.bus_sel == 4'd8 ? rg : bus_if.bus_sel == 4'd9 ? bus_if.din : 16'h0000;
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++)
            if (seed) rf[i] <= 16'h1000 + 16'(i) * 16'h0123;
            else if (bus_if.r_in[i]) rf[i] <= dbus;
        if (bus_if.a_in) ra <= dbus;
        if (bus_if.g_in) rg <= bus_if.addsub ? ra - dbus : ra + dbus;
    end
    function automatic logic [17:0] ex(input logic [7:0] r, input logic a, input logic g, input logic s,
                                       input logic [3:0] sel, input logic d, input logic b, input logic il);
        return {r, a, g, s, sel, d, b, il};
    endfunction
    task automatic put(input logic rst, input logic run, input logic [15:0] din, input logic [17:0] e);
        sq.push_back({rst, run, din});
        eq.push_back(e);
    endtask
    task automatic test_reset();
        stim_t s;
        logic [17:0] e;
        int n = 0;
        seed = 1'b1;
        bus_if.run = 1'b1;
        bus_if.din = 16'h0A80;
        @(posedge clock);
        #1 seed = 1'b0;
        put(1, 1, 16'h0A80, IDLE);
        put(0, 0, 16'h0000, IDLE);
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL reset cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
    endtask
    task automatic test_mv();
        stim_t s;
        logic [17:0] e;
        logic [15:0] r5 = rf[5];
        int n = 0;
        put(0, 1, 16'h0A80, IDLE);
        put(0, 0, 16'h0000, ex(8'h04, 0, 0, 0, 4'd5, 1, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL mv cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
        tests++;
        if (rf[2] !== r5) begin fails++; $display("FAIL mv_r2 got %h exp %h", rf[2], r5); end
    endtask
    task automatic test_mvi();
        stim_t s;
        logic [17:0] e;
        int n = 0;
        put(0, 1, 16'h2C00, IDLE);
        put(0, 0, 16'h1234, ex(8'h08, 0, 0, 0, 4'd9, 1, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL mvi cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
        tests++;
        if (rf[3] !== 16'h1234) begin fails++; $display("FAIL mvi_r3 got %h exp 1234", rf[3]); end
    endtask
    task automatic test_back_to_back();
        stim_t s;
        logic [17:0] e;
        logic [15:0] sum = rf[1] + rf[6];
        logic [15:0] dif = rf[7] - rf[0];
        int n = 0;
        put(0, 1, 16'h4700, IDLE);
        put(0, 1, 16'h4700, ex(8'h00, 1, 0, 0, 4'd1, 0, 1, 0));
        put(0, 1, 16'h4700, ex(8'h00, 0, 1, 0, 4'd6, 0, 1, 0));
        put(0, 1, 16'h4700, ex(8'h02, 0, 0, 0, 4'd8, 1, 1, 0));
        put(0, 1, 16'h7C00, IDLE);
        put(0, 1, 16'h7C00, ex(8'h00, 1, 0, 0, 4'd7, 0, 1, 0));
        put(0, 1, 16'h7C00, ex(8'h00, 0, 1, 1, 4'd0, 0, 1, 0));
        put(0, 1, 16'h7C00, ex(8'h80, 0, 0, 0, 4'd8, 1, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL addsub cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
        tests++;
        if (rf[1] !== sum) begin fails++; $display("FAIL add_r1 got %h exp %h", rf[1], sum); end
        tests++;
        if (rf[7] !== dif) begin fails++; $display("FAIL sub_r7 got %h exp %h", rf[7], dif); end
    endtask
    task automatic test_same_reg();
        stim_t s;
        logic [17:0] e;
        logic [15:0] dbl = rf[4] + rf[4];
        int n = 0;
        put(0, 1, 16'h1200, IDLE);
        put(0, 0, 16'h0000, ex(8'h10, 0, 0, 0, 4'd4, 1, 1, 0));
        put(0, 1, 16'h5200, IDLE);
        put(0, 0, 16'h0000, ex(8'h00, 1, 0, 0, 4'd4, 0, 1, 0));
        put(0, 0, 16'h0000, ex(8'h00, 0, 1, 0, 4'd4, 0, 1, 0));
        put(0, 0, 16'h0000, ex(8'h10, 0, 0, 0, 4'd8, 1, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL same_reg cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
        tests++;
        if (rf[4] !== dbl) begin fails++; $display("FAIL double_r4 got %h exp %h", rf[4], dbl); end
    endtask
    task automatic test_illegal();
        stim_t s;
        logic [17:0] e;
        int n = 0;
        put(0, 1, 16'h8000, IDLE);
        put(0, 0, 16'h0000, ex(8'h00, 0, 0, 0, 4'd15, 1, 1, 1));
        put(0, 1, 16'hE380, IDLE);
        put(0, 0, 16'h0000, ex(8'h00, 0, 0, 0, 4'd15, 1, 1, 1));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL illegal cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
    endtask
    task automatic test_reset_mid_add();
        stim_t s;
        logic [17:0] e;
        logic [15:0] r1 = rf[1];
        int n = 0;
        put(0, 1, 16'h4700, IDLE);
        put(0, 0, 16'h0000, ex(8'h00, 1, 0, 0, 4'd1, 0, 1, 0));
        put(1, 0, 16'h0000, ex(8'h00, 0, 1, 0, 4'd6, 0, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        put(0, 1, 16'h0A80, IDLE);
        put(0, 0, 16'h0000, ex(8'h04, 0, 0, 0, 4'd5, 1, 1, 0));
        put(0, 0, 16'h0000, IDLE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            reset = s.rst; bus_if.run = s.run; bus_if.din = s.din;
            @(negedge clock);
            e = eq.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL reset_mid cyc %0d got %h exp %h", n, obs, e); end
            @(posedge clock); #1 n++;
        end
        tests++;
        if (rf[1] !== r1) begin fails++; $display("FAIL reset_mid_r1 got %h exp %h", rf[1], r1); end
        tests++;
        if (rf[2] !== rf[5]) begin fails++; $display("FAIL reset_mid_r2 got %h exp %h", rf[2], rf[5]); end
    endtask
    initial begin
        bus_if.run = 1'b0;
        bus_if.din = 16'h0000;
        test_reset();
        test_mv();
        test_mvi();
        test_back_to_back();
        test_same_reg();
        test_illegal();
        test_reset_mid_add();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
